wb_byte_master: RTL

WB_BYTE_MASTER -- requirements
Module: wb_byte_master

---
 rtl/wb_byte_pkg.sv | 24 ++
 rtl/wb_byte_shifter.sv | 35 +++
 rtl/wb_byte_master.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/wb_byte_pkg.sv
// Shared constants for the byte-stream to Wishbone bridge: opcodes,
// response codes and FSM state encoding.
package wb_byte_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;  // 'W'
  localparam logic [7:0] OP_RD   = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_TMO = 8'h45;  // 'E'
  localparam logic [7:0] RSP_BAD = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RESP
  } state_t;

  // Single-byte responses sit in the top byte so they go out first.
  function automatic logic [31:0] rsp_word(input logic [7:0] code);
    return {code, 24'h0};
  endfunction

endpackage

// File: rtl/wb_byte_shifter.sv
// 4-byte MSB-first shift register with a byte count; assembles incoming
// words and serializes outgoing ones (last = next shift is the 4th byte).
module wb_byte_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [2:0]  load_cnt,
  input  logic        shift,
  input  logic [7:0]  shift_in,
  output logic [31:0] data,
  output logic        last
);

  logic [2:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      cnt  <= '0;
    end else if (load) begin
      data <= load_data;
      cnt  <= load_cnt;
    end else if (shift) begin
      data <= {data[23:0], shift_in};
      cnt  <= cnt + 3'd1;
    end else if (clr) begin
      cnt  <= '0;
    end
  end

  assign last = (cnt == 3'd3);

endmodule

// File: rtl/wb_byte_master.sv
// Byte-stream command interface driving a Wishbone classic master port:
// frames 'W'/'R' + address (+ data), issues one access, returns a response.
module wb_byte_master
  import wb_byte_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [3:0]  SEL_DEFAULT = 4'hF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        in_valid_i,
  input  logic [7:0]  in_data_i,
  output logic        in_ready_o,
  output logic        out_valid_o,
  output logic [7:0]  out_data_o,
  input  logic        out_ready_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic        busy_o
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state, nxt;
  logic        run_q, cyc_q, cyc_d, we_q;
  logic [15:0] tmo_q;
  logic        in_fire, out_fire, ack_ok, tmo_hit;
  logic        adr_clr, adr_shift, adr_last;
  logic        dat_clr, dat_shift, dat_load, dat_last;
  logic [31:0] adr_q, dat_q, dat_ld;
  logic [2:0]  dat_ld_cnt;
  logic [7:0]  dat_in;

  // run_q keeps in_ready low through reset and the first cycle after it.
  assign in_ready_o  = run_q && (state == S_IDLE || state == S_ADDR || state == S_WDATA);
  assign in_fire     = in_valid_i && in_ready_o;
  assign out_valid_o = (state == S_RESP);
  assign out_fire    = out_valid_o && out_ready_i;
  assign out_data_o  = dat_q[31:24];
  assign busy_o      = (state != S_IDLE);

  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = we_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = SEL_DEFAULT;

  // Ack wins over timeout when both land in the same cycle.
  assign ack_ok  = cyc_q && wb_ack_i;
  assign tmo_hit = cyc_q && !wb_ack_i && (tmo_q == TMO_LAST);
  assign dat_in  = (state == S_WDATA) ? in_data_i : 8'h00;

  wb_byte_shifter u_adr (
    .clk(wb_clk_i), .rst_n(wb_rst_n_i), .clr(adr_clr), .load(1'b0),
    .load_data(32'h0), .load_cnt(3'd0), .shift(adr_shift), .shift_in(in_data_i),
    .data(adr_q), .last(adr_last)
  );

  // Write data on the way in, response bytes on the way out.
  wb_byte_shifter u_dat (
    .clk(wb_clk_i), .rst_n(wb_rst_n_i), .clr(dat_clr), .load(dat_load),
    .load_data(dat_ld), .load_cnt(dat_ld_cnt), .shift(dat_shift), .shift_in(dat_in),
    .data(dat_q), .last(dat_last)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= S_IDLE;
    else             state <= nxt;
  end

  always_comb begin
    nxt        = state;
    adr_clr    = 1'b0;
    adr_shift  = 1'b0;
    dat_clr    = 1'b0;
    dat_shift  = 1'b0;
    dat_load   = 1'b0;
    dat_ld     = '0;
    dat_ld_cnt = '0;
    case (state)
      S_IDLE: if (in_fire) begin
        if (in_data_i == OP_WR || in_data_i == OP_RD) begin
          nxt     = S_ADDR;
          adr_clr = 1'b1;
        end else begin
          nxt        = S_RESP;
          dat_load   = 1'b1;
          dat_ld     = rsp_word(RSP_BAD);
          dat_ld_cnt = 3'd3;
        end
      end
      S_ADDR: if (in_fire) begin
        adr_shift = 1'b1;
        if (adr_last) begin
          nxt     = we_q ? S_WDATA : S_BUS;
          dat_clr = we_q;
        end
      end
      S_WDATA: if (in_fire) begin
        dat_shift = 1'b1;
        if (dat_last) nxt = S_BUS;
      end
      S_BUS: begin
        if (ack_ok) begin
          nxt        = S_RESP;
          dat_load   = 1'b1;
          dat_ld     = we_q ? rsp_word(RSP_OK) : wb_dat_i;
          dat_ld_cnt = we_q ? 3'd3 : 3'd0;
        end else if (tmo_hit) begin
          nxt        = S_RESP;
          dat_load   = 1'b1;
          dat_ld     = rsp_word(RSP_TMO);
          dat_ld_cnt = 3'd3;
        end
      end
      S_RESP: if (out_fire) begin
        dat_shift = 1'b1;
        if (dat_last) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
    // cyc comes up one cycle after entering BUS and falls on the edge that leaves it.
    cyc_d = (state == S_BUS) && (nxt == S_BUS);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      run_q <= 1'b0;
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      tmo_q <= '0;
    end else begin
      run_q <= 1'b1;
      cyc_q <= cyc_d;
      if (state == S_IDLE && in_fire) we_q <= (in_data_i == OP_WR);
      tmo_q <= (cyc_q && !wb_ack_i && !tmo_hit) ? tmo_q + 16'd1 : 16'd0;
    end
  end

endmodule
